ct_pt_add_stream: RTL and testbench

Sequential, parametrised ciphertext–plaintext add/subtract engine: B' = (B ± Δ·Γ) mod q and A' = A mod q over N slots. It processes LANES slots per cycle, with valid/ready handshakes on input and output. It sits between the ciphertext register file and downstream homomorphic ops, and supersedes the purely combinational CT+PT adder. Subtract mode and non-canonical-input detection are new.

---
 rtl/ct_pt_add_stream.sv | 210 +++++++++++++++++++++
 tb/tb_ct_pt_add_stream.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_pt_add_stream.sv
// ---------------------------------------------------------------------------
// ct_pt_add_stream
//
// Sequential ciphertext + plaintext add/subtract engine. For every slot i it
// produces A'[i] = A[i] mod q and B'[i] = (B[i] +/- DELTAP*Gamma[i]) mod q,
// handling LANES slots per clock over N/LANES beats.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid        A, B, Gamma and mode are presented
//   in_ready        engine idle and able to take a new ciphertext
//   in_mode         0 = add, 1 = subtract
//   in_a/in_b       ciphertext slots, N x W packed, slot i at [i*W +: W]
//   in_gamma        plaintext slots, same packing
//   out_valid       result available, held until out_ready
//   out_ready       downstream consumes the result
//   out_a/out_b     canonical result slots in [0, q)
//   out_noncanon    some input A or B slot of this result was >= q
// ---------------------------------------------------------------------------
module ct_pt_add_stream #(
    parameter int N      = 8,
    parameter int W      = 16,
    parameter int LANES  = 2,
    parameter int QP     = 7710,
    parameter int DELTAP = 30
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_mode,
    input  logic [N*W-1:0] in_a,
    input  logic [N*W-1:0] in_b,
    input  logic [N*W-1:0] in_gamma,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_a,
    output logic [N*W-1:0] out_b,
    output logic           out_noncanon
);

    localparam int BEATS = N / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [W-1:0]   QW   = W'(QP);
    localparam logic [2*W-1:0] QW2  = (2*W)'(QP);
    localparam logic [2*W-1:0] DW2  = (2*W)'(DELTAP);
    localparam logic [BW-1:0]  LAST = BW'(BEATS - 1);

    // Reject configurations the datapath cannot represent correctly.
    generate
        if (LANES < 1 || (N % LANES) != 0 || QP < 2 ||
            longint'(QP) >= (longint'(1) << W) || DELTAP >= QP) begin : gParamCheck
            $error("ct_pt_add_stream: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [N*W-1:0] aReg_q, aReg_d;
    logic [N*W-1:0] bReg_q, bReg_d;
    logic [N*W-1:0] gReg_q, gReg_d;
    logic           mode_q, mode_d;
    logic           ncAcc_q, ncAcc_d;
    logic [N*W-1:0] outA_q, outA_d;
    logic [N*W-1:0] outB_q, outB_d;
    logic           outNc_q, outNc_d;

    logic [W-1:0]     laneA [LANES];
    logic [W-1:0]     laneB [LANES];
    logic [LANES-1:0] laneNc;

    // Per-lane modular arithmetic on the slots selected by the current beat.
    // The subtract path adds q before subtracting when b < p so the result
    // never goes negative; b + (q - p) stays below q because b < p.
    always_comb begin : laneMath
        logic [W-1:0]   aIn, bIn, gIn, bMod, pMod;
        logic [2*W-1:0] prod;
        logic [W:0]     sum;
        int             slot;
        laneA  = '{default: '0};
        laneB  = '{default: '0};
        laneNc = '0;
        aIn    = '0;
        bIn    = '0;
        gIn    = '0;
        bMod   = '0;
        pMod   = '0;
        prod   = '0;
        sum    = '0;
        slot   = 0;
        for (int l = 0; l < LANES; l++) begin
            slot      = int'(beat_q) * LANES + l;
            aIn       = aReg_q[slot*W +: W];
            bIn       = bReg_q[slot*W +: W];
            gIn       = gReg_q[slot*W +: W];
            laneNc[l] = (aIn >= QW) || (bIn >= QW);
            laneA[l]  = aIn % QW;
            bMod      = bIn % QW;
            prod      = {{W{1'b0}}, gIn} * DW2;
            pMod      = W'(prod % QW2);
            if (!mode_q) begin
                sum = {1'b0, bMod} + {1'b0, pMod};
                if (sum >= {1'b0, QW}) begin
                    sum = sum - {1'b0, QW};
                end
                laneB[l] = sum[W-1:0];
            end else if (bMod >= pMod) begin
                laneB[l] = bMod - pMod;
            end else begin
                laneB[l] = bMod + (QW - pMod);
            end
        end
    end

    // Next-state logic. IDLE captures the whole ciphertext so later port
    // changes cannot disturb it; RUN writes one beat of slots per cycle and
    // folds that beat's non-canonical flags into the accumulator; the final
    // beat's flags are included directly when publishing out_noncanon.
    always_comb begin : fsmNext
        int slot;
        state_d = state_q;
        beat_d  = beat_q;
        aReg_d  = aReg_q;
        bReg_d  = bReg_q;
        gReg_d  = gReg_q;
        mode_d  = mode_q;
        ncAcc_d = ncAcc_q;
        outA_d  = outA_q;
        outB_d  = outB_q;
        outNc_d = outNc_q;
        slot    = 0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    aReg_d  = in_a;
                    bReg_d  = in_b;
                    gReg_d  = in_gamma;
                    mode_d  = in_mode;
                    beat_d  = '0;
                    ncAcc_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    slot                  = int'(beat_q) * LANES + l;
                    outA_d[slot*W +: W]   = laneA[l];
                    outB_d[slot*W +: W]   = laneB[l];
                end
                ncAcc_d = ncAcc_q | (|laneNc);
                if (beat_q == LAST) begin
                    outNc_d = ncAcc_q | (|laneNc);
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset aborts any transaction and clears results so no
    // partially computed ciphertext can be mistaken for a valid one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            aReg_q  <= '0;
            bReg_q  <= '0;
            gReg_q  <= '0;
            mode_q  <= 1'b0;
            ncAcc_q <= 1'b0;
            outA_q  <= '0;
            outB_q  <= '0;
            outNc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            aReg_q  <= aReg_d;
            bReg_q  <= bReg_d;
            gReg_q  <= gReg_d;
            mode_q  <= mode_d;
            ncAcc_q <= ncAcc_d;
            outA_q  <= outA_d;
            outB_q  <= outB_d;
            outNc_q <= outNc_d;
        end
    end

    assign in_ready     = (state_q == IDLE) && !rst;
    assign out_valid    = (state_q == DONE);
    assign out_a        = outA_q;
    assign out_b        = outB_q;
    assign out_noncanon = outNc_q;

endmodule

// File: tb/tb_ct_pt_add_stream.sv
// ---------------------------------------------------------------------------
// tb_ct_pt_add_stream
//
// Self-checking bench for ct_pt_add_stream. A table of hand-computed vectors
// runs through the default configuration, followed by hand-written
// backpressure and mid-RUN reset sequences. Three extra instances
// (LANES = 1, 2, 8 with N=16, W=20, q=786433, delta=3000) are driven with
// random ciphertexts and compared against a software model.
// ---------------------------------------------------------------------------
module tb_ct_pt_add_stream;

    localparam int N = 8;
    localparam int W = 16;

    localparam int SN = 16;
    localparam int SW = 20;
    localparam int SQ = 786433;
    localparam int SD = 3000;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic           in_mode;
    logic [N*W-1:0] in_a;
    logic [N*W-1:0] in_b;
    logic [N*W-1:0] in_gamma;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_a;
    logic [N*W-1:0] out_b;
    logic           out_noncanon;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ct_pt_add_stream dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mode     (in_mode),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_gamma    (in_gamma),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_noncanon(out_noncanon)
    );

    typedef struct {
        string name;
        logic  mode;
        int    a  [8];
        int    b  [8];
        int    g  [8];
        int    ea [8];
        int    eb [8];
        logic  enc;
    } vec_t;

    vec_t vecs [7];

    // Packs eight slot values into the port layout, slot 0 in the low bits.
    function automatic logic [N*W-1:0] pack8(input int s [8]);
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i*W +: W] = W'(s[i]);
        end
        return r;
    endfunction

    // One comparison: counts it and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [SN*SW-1:0] act,
                               input logic [SN*SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one complete transaction: accept, scramble the input ports to show
    // the latched copy is used, measure latency, compare, then consume.
    task automatic applyStimulus(input vec_t v);
        int waitCyc;
        int lat;
        @(negedge clk);
        in_mode  = v.mode;
        in_a     = pack8(v.a);
        in_b     = pack8(v.b);
        in_gamma = pack8(v.g);
        in_valid = 1'b1;
        waitCyc  = 0;
        while (!in_ready && waitCyc < 20) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput({v.name, " in_ready"}, in_ready, 1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_b     = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_gamma = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_mode  = ~v.mode;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({v.name, " latency"}, lat, 4);
        checkOutput({v.name, " out_a"}, out_a, pack8(v.ea));
        checkOutput({v.name, " out_b"}, out_b, pack8(v.eb));
        checkOutput({v.name, " out_noncanon"}, out_noncanon, v.enc);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({v.name, " out_valid after consume"}, out_valid, 0);
    endtask

    // -----------------------------------------------------------------------
    // Parameter sweep instances with a software reference model.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < 3; gi++) begin : gSweep
        localparam int L = (gi == 0) ? 1 : (gi == 1) ? 2 : 8;

        logic             done;
        logic             sRst;
        logic             sInV;
        logic             sInR;
        logic             sMode;
        logic             sOutV;
        logic             sOutR;
        logic             sNc;
        logic [SN*SW-1:0] sA, sB, sG, sOA, sOB, eA, eB;
        logic             eNc;

        ct_pt_add_stream #(
            .N     (SN),
            .W     (SW),
            .LANES (L),
            .QP    (SQ),
            .DELTAP(SD)
        ) uSweep (
            .clk         (clk),
            .rst         (sRst),
            .in_valid    (sInV),
            .in_ready    (sInR),
            .in_mode     (sMode),
            .in_a        (sA),
            .in_b        (sB),
            .in_gamma    (sG),
            .out_valid   (sOutV),
            .out_ready   (sOutR),
            .out_a       (sOA),
            .out_b       (sOB),
            .out_noncanon(sNc)
        );

        initial begin
            int     lat;
            int     w;
            longint a, b, g, p, s;
            done  = 1'b0;
            sRst  = 1'b1;
            sInV  = 1'b0;
            sOutR = 1'b0;
            sMode = 1'b0;
            sA    = '0;
            sB    = '0;
            sG    = '0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            sRst = 1'b0;
            for (int t = 0; t < 1000; t++) begin
                eNc   = 1'b0;
                sMode = 1'($urandom_range(0, 1));
                for (int i = 0; i < SN; i++) begin
                    a = longint'($urandom_range(0, SQ + SQ / 8));
                    b = longint'($urandom_range(0, SQ + SQ / 8));
                    g = longint'($urandom_range(0, (1 << SW) - 1));
                    sA[i*SW +: SW] = SW'(a);
                    sB[i*SW +: SW] = SW'(b);
                    sG[i*SW +: SW] = SW'(g);
                    if (a >= SQ || b >= SQ) eNc = 1'b1;
                    p = (SD * g) % SQ;
                    b = b % SQ;
                    if (!sMode) begin
                        s = b + p;
                        if (s >= SQ) s = s - SQ;
                    end else begin
                        s = (b >= p) ? (b - p) : (b + SQ - p);
                    end
                    eA[i*SW +: SW] = SW'(a % SQ);
                    eB[i*SW +: SW] = SW'(s);
                end
                @(negedge clk);
                sInV = 1'b1;
                w = 0;
                while (!sInR && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                @(posedge clk);
                #1;
                sInV = 1'b0;
                lat = 0;
                while (!sOutV && lat < 100) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                checkOutput($sformatf("sweep L%0d t%0d latency", L, t), lat, SN / L);
                checkOutput($sformatf("sweep L%0d t%0d out_a", L, t), sOA, eA);
                checkOutput($sformatf("sweep L%0d t%0d out_b", L, t), sOB, eB);
                checkOutput($sformatf("sweep L%0d t%0d noncanon", L, t), sNc, eNc);
                sOutR = 1'b1;
                @(posedge clk);
                #1;
                sOutR = 1'b0;
            end
            done = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Directed tests on the default configuration.
    // -----------------------------------------------------------------------
    initial begin
        int lat;
        int w;
        logic [N*W-1:0] heldA;
        logic [N*W-1:0] heldB;

        vecs[0] = '{name: "add", mode: 1'b0,
            a:  '{1429, 4717, 6311, 3279, 7215, 6215, 6931, 973},
            b:  '{7531, 4381, 1094, 7529, 5909, 964, 5576, 4640},
            g:  '{1, 2, 3, 4, 5, 6, 7, 8},
            ea: '{1429, 4717, 6311, 3279, 7215, 6215, 6931, 973},
            eb: '{7561, 4441, 1184, 7649, 6059, 1144, 5786, 4880},
            enc: 1'b0};
        vecs[1] = vecs[0];
        vecs[1].name = "sub";
        vecs[1].mode = 1'b1;
        vecs[1].eb   = '{7501, 4321, 1004, 7409, 5759, 784, 5366, 4400};
        vecs[2] = '{name: "wrap sub", mode: 1'b1,
            a:  '{0, 0, 0, 0, 0, 0, 0, 0},
            b:  '{10, 0, 0, 0, 0, 0, 0, 0},
            g:  '{1, 0, 0, 0, 0, 0, 0, 0},
            ea: '{0, 0, 0, 0, 0, 0, 0, 0},
            eb: '{7690, 0, 0, 0, 0, 0, 0, 0},
            enc: 1'b0};
        vecs[3] = '{name: "wrap add", mode: 1'b0,
            a:  '{0, 0, 0, 0, 0, 0, 0, 0},
            b:  '{7700, 0, 7709, 0, 0, 0, 0, 0},
            g:  '{1, 65535, 65535, 0, 0, 0, 0, 0},
            ea: '{0, 0, 0, 0, 0, 0, 0, 0},
            eb: '{20, 0, 7709, 0, 0, 0, 0, 0},
            enc: 1'b0};
        vecs[4] = '{name: "noncanon A", mode: 1'b0,
            a:  '{7710, 65535, 0, 0, 0, 0, 0, 0},
            b:  '{0, 0, 0, 0, 0, 0, 0, 0},
            g:  '{0, 0, 0, 0, 0, 0, 0, 0},
            ea: '{0, 3855, 0, 0, 0, 0, 0, 0},
            eb: '{0, 0, 0, 0, 0, 0, 0, 0},
            enc: 1'b1};
        vecs[5] = vecs[0];
        vecs[5].name = "canonical after noncanon";
        vecs[6] = '{name: "noncanon B last slot", mode: 1'b0,
            a:  '{0, 0, 0, 0, 0, 0, 0, 0},
            b:  '{0, 0, 0, 0, 0, 0, 0, 8000},
            g:  '{0, 0, 0, 0, 0, 0, 0, 0},
            ea: '{0, 0, 0, 0, 0, 0, 0, 0},
            eb: '{0, 0, 0, 0, 0, 0, 0, 290},
            enc: 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_gamma  = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_a", out_a, 0);
        checkOutput("reset out_b", out_b, 0);
        checkOutput("reset out_noncanon", out_noncanon, 0);
        checkOutput("reset in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("in_ready after reset", in_ready, 1);

        for (int k = 0; k < 7; k++) begin
            applyStimulus(vecs[k]);
        end

        // Backpressure: result held for 5 cycles while the next CT waits
        @(negedge clk);
        in_mode  = vecs[0].mode;
        in_a     = pack8(vecs[0].a);
        in_b     = pack8(vecs[0].b);
        in_gamma = pack8(vecs[0].g);
        in_valid = 1'b1;
        checkOutput("bp in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_mode  = vecs[1].mode;
        in_a     = pack8(vecs[1].a);
        in_b     = pack8(vecs[1].b);
        in_gamma = pack8(vecs[1].g);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("bp latency", lat, 4);
        heldA = pack8(vecs[0].ea);
        heldB = pack8(vecs[0].eb);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp hold%0d out_valid", c), out_valid, 1);
            checkOutput($sformatf("bp hold%0d in_ready", c), in_ready, 0);
            checkOutput($sformatf("bp hold%0d out_a", c), out_a, heldA);
            checkOutput($sformatf("bp hold%0d out_b", c), out_b, heldB);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bp idle out_valid", out_valid, 0);
        checkOutput("bp idle in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp queued accepted", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("bp queued latency", lat, 4);
        checkOutput("bp queued out_b", out_b, pack8(vecs[1].eb));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset while RUN is at beat 2
        @(negedge clk);
        in_mode  = vecs[1].mode;
        in_a     = pack8(vecs[4].a);
        in_b     = pack8(vecs[1].b);
        in_gamma = pack8(vecs[1].g);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrun rst out_valid", out_valid, 0);
        checkOutput("midrun rst out_a", out_a, 0);
        checkOutput("midrun rst out_b", out_b, 0);
        checkOutput("midrun rst out_noncanon", out_noncanon, 0);
        checkOutput("midrun rst in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrun in_ready after rst", in_ready, 1);
        applyStimulus(vecs[0]);

        // Wait for the sweep instances, bounded
        w = 0;
        while (!(gSweep[0].done && gSweep[1].done && gSweep[2].done) && w < 60000) begin
            @(posedge clk);
            w++;
        end
        checkOutput("sweep completion",
                    {gSweep[2].done, gSweep[1].done, gSweep[0].done}, 3'b111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
